// File: rtl/ir_port_ctrl.sv
// Half-duplex IR port: pulse-coded UART-style transmitter and receiver sharing one optical path.
// Define IR_RX_ERR_CNT_EN to add the saturating rx_err_cnt framing-error counter output.
module ir_port_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int GUARD_TICKS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
`ifdef IR_RX_ERR_CNT_EN
  output logic [7:0] rx_err_cnt,
`endif
  output logic       ir_tx,
  input  logic       ir_rx,
  output logic       ir_rx_disable
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (GUARD_TICKS > 16) ? $clog2(GUARD_TICKS) + 1 : 5;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_TICKS - 1);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_GUARD = 2'd2} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_HALF = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [PW-1:0]   tx_pre_q, tx_pre_d;
  logic [TW-1:0]   tx_tick_q, tx_tick_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [9:0]      tx_frame_q, tx_frame_d;
  logic            ir_tx_q, ir_tx_d;

  logic [1:0]      rx_sync_q, rx_sync_d;
  logic            rx_prev_q, rx_prev_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic [PW-1:0]   rx_pre_q, rx_pre_d;
  logic [3:0]      rx_tick_q, rx_tick_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic            rx_seen_q, rx_seen_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;

  logic            rx_edge;
  logic            tx_accept;
  logic            tx_tick_evt;
  logic            rx_tick_evt;
  logic            rx_stop_end;

  // Reception wins over a same-cycle transmit request because tx_ready drops on an edge.
  assign rx_edge       = rx_prev_q & ~rx_sync_q[1];
  assign tx_ready      = (tx_state_q == TX_IDLE) && (rx_state_q == RX_IDLE) && !rx_edge;
  assign ir_rx_disable = !rx_enable || (tx_state_q != TX_IDLE);
  assign tx_accept     = tx_valid && tx_ready;
  assign tx_tick_evt   = (tx_pre_q == PRE_LAST);
  assign rx_tick_evt   = (rx_pre_q == PRE_LAST);
  assign rx_stop_end   = !ir_rx_disable && (rx_state_q == RX_STOP) && rx_tick_evt && (rx_tick_q == 4'd15);

  assign ir_tx    = ir_tx_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  // Transmit sequencing: frame position and the next-cycle LED level.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_pre_d   = tx_pre_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_frame_d = tx_frame_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_pre_d = PW'(0);
        if (tx_accept) begin
          tx_state_d = TX_SEND;
          tx_tick_d  = TW'(0);
          tx_bit_d   = 4'd0;
          tx_frame_d = {1'b1, tx_data, 1'b0};
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_SEND: begin
        tx_pre_d = tx_tick_evt ? PW'(0) : tx_pre_q + PW'(1);
        if (tx_tick_evt && (tx_tick_q != TW'(15))) begin
          tx_tick_d = tx_tick_q + TW'(1);
        end else if (tx_tick_evt && (tx_bit_q != 4'd9)) begin
          tx_tick_d = TW'(0);
          tx_bit_d  = tx_bit_q + 4'd1;
        end else if (tx_tick_evt) begin
          tx_tick_d  = TW'(0);
          tx_state_d = TX_GUARD;
        end else begin
          tx_tick_d = tx_tick_q;
        end
      end
      TX_GUARD: begin
        tx_pre_d = tx_tick_evt ? PW'(0) : tx_pre_q + PW'(1);
        if (tx_tick_evt && (tx_tick_q == GUARD_LAST)) begin
          tx_tick_d  = TW'(0);
          tx_state_d = TX_IDLE;
        end else if (tx_tick_evt) begin
          tx_tick_d = tx_tick_q + TW'(1);
        end else begin
          tx_tick_d = tx_tick_q;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase
    // A zero bit lights the LED for the first three ticks of its period.
    ir_tx_d = (tx_state_d == TX_SEND) && !tx_frame_d[tx_bit_d] && (tx_tick_d < TW'(3));
  end

  // Receive sequencing: edge-per-window decoding and strobe generation.
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], ir_rx};
    rx_prev_d  = rx_sync_q[1];
    rx_state_d = rx_state_q;
    rx_pre_d   = rx_pre_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_seen_d  = rx_seen_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (ir_rx_disable) begin
      rx_state_d = RX_IDLE;
      rx_pre_d   = PW'(0);
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_pre_d = PW'(0);
          if (rx_edge) begin
            rx_state_d = RX_HALF;
            rx_tick_d  = 4'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
        RX_HALF: begin
          rx_pre_d = rx_tick_evt ? PW'(0) : rx_pre_q + PW'(1);
          if (rx_tick_evt && (rx_tick_q == 4'd7)) begin
            rx_state_d = RX_DATA;
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
            rx_seen_d  = 1'b0;
          end else if (rx_tick_evt) begin
            rx_tick_d = rx_tick_q + 4'd1;
          end else begin
            rx_tick_d = rx_tick_q;
          end
        end
        RX_DATA: begin
          rx_pre_d  = rx_tick_evt ? PW'(0) : rx_pre_q + PW'(1);
          rx_seen_d = rx_seen_q | rx_edge;
          if (rx_tick_evt && (rx_tick_q == 4'd15)) begin
            rx_shift_d = {~(rx_seen_q | rx_edge), rx_shift_q[7:1]};
            rx_seen_d  = 1'b0;
            rx_tick_d  = 4'd0;
            if (rx_bit_q == 3'd7) begin
              rx_state_d = RX_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end else if (rx_tick_evt) begin
            rx_tick_d = rx_tick_q + 4'd1;
          end else begin
            rx_tick_d = rx_tick_q;
          end
        end
        RX_STOP: begin
          rx_pre_d  = rx_tick_evt ? PW'(0) : rx_pre_q + PW'(1);
          rx_seen_d = rx_seen_q | rx_edge;
          if (rx_stop_end) begin
            rx_state_d = RX_IDLE;
            rx_seen_d  = 1'b0;
            if (rx_seen_q | rx_edge) begin
              rx_data_d = rx_data_q;
            end else begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
            end
          end else if (rx_tick_evt) begin
            rx_tick_d = rx_tick_q + 4'd1;
          end else begin
            rx_tick_d = rx_tick_q;
          end
        end
        default: begin
          rx_state_d = RX_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_pre_q   <= PW'(0);
      tx_tick_q  <= TW'(0);
      tx_bit_q   <= 4'd0;
      tx_frame_q <= 10'h3FF;
      ir_tx_q    <= 1'b0;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_pre_q   <= PW'(0);
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_seen_q  <= 1'b0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_pre_q   <= tx_pre_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
      ir_tx_q    <= ir_tx_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_pre_q   <= rx_pre_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_seen_q  <= rx_seen_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef IR_RX_ERR_CNT_EN
  logic       rx_frame_err;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign rx_frame_err = rx_stop_end && (rx_seen_q | rx_edge);
  assign rx_err_cnt   = err_cnt_q;

  // Framing-error count, saturating at all ones.
  always_comb begin
    if (rx_frame_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule
